// File: rtl/mpu_elementwise_seq.sv
// rtl/mpu_elementwise_seq.sv - sequential element-wise A+B / A-B over a DIMxDIM signed matrix
// Processes LANES elements per RUN beat with wrap or saturating arithmetic and a sticky overflow flag.
module mpu_elementwise_seq #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8,
  parameter int LANES = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       op_sub,
  input  logic                       sat_en,
  input  logic [WIDTH*DIM*DIM-1:0]   matrix_a,
  input  logic [WIDTH*DIM*DIM-1:0]   matrix_b,
  output logic [WIDTH*DIM*DIM-1:0]   result,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam int ELEMS  = DIM * DIM;
  localparam int VEC_W  = WIDTH * ELEMS;
  localparam int NBEATS = (ELEMS + LANES - 1) / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [VEC_W-1:0]   a_q, a_d;
  logic [VEC_W-1:0]   b_q, b_d;
  logic               op_sub_q, op_sub_d;
  logic               sat_en_q, sat_en_d;
  logic [VEC_W-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  logic [WIDTH:0]     lane_res;

  // Returns {overflow, stored value}; the sum is formed one bit wider so overflow is a sign mismatch.
  function automatic logic [WIDTH:0] elem_op(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sub,
                                             input logic             sat);
    logic [WIDTH:0]   ea;
    logic [WIDTH:0]   eb;
    logic [WIDTH:0]   s;
    logic             ovf;
    logic [WIDTH-1:0] v;
    ea  = {a[WIDTH-1], a};
    eb  = {b[WIDTH-1], b};
    s   = sub ? (ea - eb) : (ea + eb);
    ovf = s[WIDTH] ^ s[WIDTH-1];
    if (ovf && sat) begin
      v = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      v = s[WIDTH-1:0];
    end
    return {ovf, v};
  endfunction

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    a_d        = a_q;
    b_d        = b_q;
    op_sub_d   = op_sub_q;
    sat_en_d   = sat_en_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    lane_res   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = matrix_a;
          b_d        = matrix_b;
          op_sub_d   = op_sub;
          sat_en_d   = sat_en;
          result_d   = '0;
          overflow_d = 1'b0;
          beat_d     = '0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          // Lanes past the last element on a partial final beat write nothing.
          if ((int'(beat_q) * LANES + l) < ELEMS) begin
            lane_res = elem_op(a_q[(int'(beat_q) * LANES + l) * WIDTH +: WIDTH],
                               b_q[(int'(beat_q) * LANES + l) * WIDTH +: WIDTH],
                               op_sub_q, sat_en_q);
            result_d[(int'(beat_q) * LANES + l) * WIDTH +: WIDTH] = lane_res[WIDTH-1:0];
            overflow_d = overflow_d | lane_res[WIDTH];
          end
        end
        if (beat_q == BEAT_W'(NBEATS - 1)) begin
          beat_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_sub_q   <= 1'b0;
      sat_en_q   <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_sub_q   <= op_sub_d;
      sat_en_q   <= sat_en_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mpu_elementwise_seq.sv
// tb/tb_mpu_elementwise_seq.sv - directed self-checking bench for mpu_elementwise_seq
// Covers wrap/saturate, add/sub, partial final beat (LANES=4), ignored start and mid-run reset.
module tb_mpu_elementwise_seq;

  localparam int DIM = 5;
  localparam int W   = 8;
  localparam int E   = DIM * DIM;
  localparam int VW  = W * E;

  logic          clk;
  logic          rst_n;
  logic          start, op_sub, sat_en;
  logic [VW-1:0] matrix_a, matrix_b, result;
  logic          busy, done, overflow;
  logic          start1, op_sub1, sat_en1;
  logic [VW-1:0] matrix_a1, matrix_b1, result1;
  logic          busy1, done1, overflow1;

  int n_total = 0;
  int n_pass  = 0;

  mpu_elementwise_seq #(.DIM(5), .WIDTH(8), .LANES(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .sat_en(sat_en),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .result(result),
    .busy(busy), .done(done), .overflow(overflow)
  );

  mpu_elementwise_seq #(.DIM(5), .WIDTH(8), .LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_sub(op_sub1), .sat_en(sat_en1),
    .matrix_a(matrix_a1), .matrix_b(matrix_b1), .result(result1),
    .busy(busy1), .done(done1), .overflow(overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [VW-1:0] fill(input logic [W-1:0] v);
    logic [VW-1:0] m;
    for (int i = 0; i < E; i++) m[i*W +: W] = v;
    return m;
  endfunction

  // Launch on dut, optionally pulse a second start mid-run with other operands.
  // Returns in the done cycle (or after the cycle budget expires).
  task automatic run_op(input logic sub, input logic sat, input bit glitch,
                        output int busy_cycles, output bit got_done);
    @(negedge clk);
    start = 1'b1; op_sub = sub; sat_en = sat;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (done) got_done = 1'b1;
      else if (busy) busy_cycles++;
      if (glitch && c == 1) begin
        matrix_a = fill(8'd50); matrix_b = fill(8'd50);
        op_sub = 1'b0; sat_en = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (!got_done) @(negedge clk);
    end
  endtask

  int            bc;
  bit            gd;
  logic [VW-1:0] exp_m;
  logic [VW-1:0] held;

  initial begin
    rst_n = 1'b0;
    start = 1'b0; op_sub = 1'b0; sat_en = 1'b0;
    matrix_a = '0; matrix_b = '0;
    start1 = 1'b0; op_sub1 = 1'b0; sat_en1 = 1'b0;
    matrix_a1 = '0; matrix_b1 = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;

    matrix_a = fill(8'd10); matrix_b = fill(8'd3);
    run_op(1'b1, 1'b0, 1'b0, bc, gd);
    check("sub_done", gd, 1'b1);
    check("sub_busy_cycles", bc, 5);
    check("sub_result", result, fill(8'd7));
    check("sub_ovf", overflow, 1'b0);
    check("sub_busy_in_done", busy, 1'b0);
    held = result;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("result_held", result, held);

    matrix_a = '0; matrix_b = '0;
    matrix_a[0 +: W] = 8'h80; matrix_b[0 +: W] = 8'h01;
    exp_m = '0; exp_m[0 +: W] = 8'h7f;
    run_op(1'b1, 1'b0, 1'b0, bc, gd);
    check("minsub_wrap_res", result, exp_m);
    check("minsub_wrap_ovf", overflow, 1'b1);
    exp_m[0 +: W] = 8'h80;
    run_op(1'b1, 1'b1, 1'b0, bc, gd);
    check("minsub_sat_res", result, exp_m);
    check("minsub_sat_ovf", overflow, 1'b1);

    matrix_a = fill(8'd100); matrix_b = fill(8'd100);
    run_op(1'b0, 1'b1, 1'b0, bc, gd);
    check("add_sat_res", result, fill(8'h7f));
    check("add_sat_ovf", overflow, 1'b1);
    run_op(1'b0, 1'b0, 1'b0, bc, gd);
    check("add_wrap_res", result, fill(8'hc8));
    check("add_wrap_ovf", overflow, 1'b1);

    matrix_a = fill(8'd10); matrix_b = fill(8'd3);
    run_op(1'b1, 1'b0, 1'b1, bc, gd);
    check("glitch_done", gd, 1'b1);
    check("glitch_busy_cycles", bc, 5);
    check("glitch_result", result, fill(8'd7));
    check("glitch_ovf", overflow, 1'b0);
    // Next start lands in the first IDLE cycle after done.
    matrix_a = fill(8'd1); matrix_b = fill(8'd2);
    run_op(1'b0, 1'b0, 1'b0, bc, gd);
    check("b2b_done", gd, 1'b1);
    check("b2b_busy_cycles", bc, 5);
    check("b2b_result", result, fill(8'd3));

    matrix_a = fill(8'd127); matrix_b = fill(8'hff);
    @(negedge clk);
    start = 1'b1; op_sub = 1'b1; sat_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_ovf", overflow, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_busy", busy, 1'b0);
    check("postrst_result", result, '0);
    matrix_a = fill(8'hfb); matrix_b = fill(8'd2);
    run_op(1'b1, 1'b0, 1'b0, bc, gd);
    check("postrst_done", gd, 1'b1);
    check("postrst_res", result, fill(8'hf9));
    check("postrst_ovf", overflow, 1'b0);

    for (int i = 0; i < E; i++) begin
      matrix_a1[i*W +: W] = 8'(i);
      matrix_b1[i*W +: W] = 8'(2 * i);
      exp_m[i*W +: W]     = 8'(0 - i);
    end
    @(negedge clk);
    start1 = 1'b1; op_sub1 = 1'b1; sat_en1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    bc = 0;
    gd = 1'b0;
    for (int c = 0; c < 20 && !gd; c++) begin
      if (done1) gd = 1'b1;
      else if (busy1) bc++;
      if (!gd) @(negedge clk);
    end
    check("l4_done", gd, 1'b1);
    check("l4_busy_cycles", bc, 7);
    check("l4_result", result1, exp_m);
    check("l4_ovf", overflow1, 1'b0);
    @(negedge clk);
    check("l4_done_one_cycle", done1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
